fpu_esc_dispatcher: RTL and testbench
=====================================

# fpu_esc_dispatcher

Upstream issue stage for the 8087 FPU integration. Accepts ESC instructions (opcode D8h–DFh, ModR/M, operand data) from the CPU bus interface and buffers them in a small in-order FIFO. Issues them one at a time to the direct FPU wrapper using its one-cycle `execute` / `ready` protocol, holding operands stable until completion. Also reports queue occupancy, sticky FPU error, and a completion watchdog timeout.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `TIMEOUT`, 1023, max cycles in WAIT_DONE before abort; ≥2
- `clk`  in  1  clock, rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `esc_valid`  in  1  CPU offers an instruction
- `esc_ready`  out  1  FIFO can accept (= !full)
- `esc_opcode`  in  8  raw opcode byte
- `esc_modrm`  in  8  ModR/M byte
- `esc_data`  in  80  memory/real operand
- `esc_int_data`  in  32  integer operand
- `fpu_opcode`  out  8  head opcode to FPU
- `fpu_modrm`  out  8  head ModR/M to FPU
- `fpu_data_in`  out  80  head real operand
- `fpu_int_data_in`  out  32  head integer operand
- `fpu_execute`  out  1  one-cycle start pulse, registered
- `fpu_ready`  in  1  FPU idle / instruction complete
- `fpu_error`  in  1  FPU exception flag, sampled at completion
- `err_clear`  in  1  clears `err_sticky` and `timeout`
- `busy`  out  1  queue non-empty or state ≠ IDLE
- `queue_count`  out  $clog2(DEPTH)+1  entries held (including the in-flight one)
- `err_sticky`  out  1  FPU reported error; dispatch halted
- `timeout`  out  1  watchdog fired; dispatch halted
- `drop`  out  1  one-cycle pulse: non-ESC opcode discarded

## Operation
- Push when `esc_valid && esc_ready`. Opcodes outside D8h–DFh are consumed without being stored, and `drop` pulses on the next cycle.
- With `esc_ready = !full`, a push is refused when full, even if a pop happens in the same cycle.
- Simultaneous push and pop: `queue_count` is unchanged; pointers wrap modulo DEPTH.
- `fpu_*` data outputs are driven from the FIFO head. They must not change from ISSUE through the end of WAIT_DONE.
- States: IDLE, ISSUE, GUARD, WAIT_DONE.
  - IDLE → ISSUE when count≠0, `fpu_ready`=1, `err_sticky`=0, `timeout`=0.
  - ISSUE → GUARD unconditionally. `fpu_execute`=1 only while in ISSUE.
  - GUARD → WAIT_DONE unconditionally. `fpu_ready` is ignored in GUARD.
  - WAIT_DONE → IDLE when `fpu_ready`=1. In that cycle: pop the head and set `err_sticky` if `fpu_error`=1.
  - WAIT_DONE → IDLE when the watchdog reaches TIMEOUT. In that cycle: pop the head and set `timeout`.
- Watchdog: counter cleared on entry to WAIT_DONE and incremented every cycle in WAIT_DONE. It fires when the count equals TIMEOUT−1 and `fpu_ready`=0. Completion takes priority over timeout in the same cycle.
- `err_clear` clears both `err_sticky` and `timeout`. If it coincides with a completion that has `fpu_error`=1, the set wins.
- Halted queue (`err_sticky` or `timeout` set): entries are retained and pushes are still accepted while not full.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, pointers and count=0, `fpu_execute`=0.
  - `esc_ready`=1, `busy`=0, `err_sticky`=0, `timeout`=0, `drop`=0.
  - `fpu_*` data outputs=0.
- Reset mid-operation discards the queue and any in-flight instruction. `fpu_execute` drops at once.
- Latency with an empty queue and the FPU ready: handshake at edge k; `fpu_execute` is high from edge k+1 to edge k+2.
- Minimum issue-to-issue spacing is 4 cycles: ISSUE, GUARD, WAIT_DONE with `fpu_ready` high, IDLE.
- `queue_count` decrements on the edge that leaves WAIT_DONE.
- `busy` is combinational from registered state.

## Test plan
- Reset with queue full, then release → all outputs at reset values, `esc_ready`=1; next push D9h/C0h gives `fpu_execute` high exactly one cycle after the handshake.
- Push 4 instructions back-to-back with `fpu_ready` tied high → 5th offer blocked (`esc_ready`=0); the 4 issue in order with exactly 4-cycle spacing; `queue_count` steps 4,3,2,1,0.
- Hold `fpu_ready` low for 10 cycles after issuing DCh/C1h → `fpu_*` data outputs stable throughout; pop occurs on the first cycle `fpu_ready`=1.
- Complete DEh/F9h with `fpu_error`=1 while 2 entries remain queued → `err_sticky`=1 and no further `fpu_execute`; `err_clear` pulse → next entry issues within 2 cycles.
- TIMEOUT=8, `fpu_ready` held low → `timeout` set after 8 WAIT_DONE cycles, entry popped, dispatch halts; also check completion on the final watchdog cycle → no timeout.
- Push opcode 90h → `drop` pulses once, `queue_count` stays 0, no `fpu_execute`.

Source files
------------

// File: rtl/fpu_esc_dispatcher.sv
// In-order issue queue between the CPU bus interface and the 8087 FPU wrapper.
// Buffers ESC instructions and issues them one at a time with an execute/ready handshake.
module fpu_esc_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      esc_valid,
    output logic                      esc_ready,
    input  logic [7:0]                esc_opcode,
    input  logic [7:0]                esc_modrm,
    input  logic [79:0]               esc_data,
    input  logic [31:0]               esc_int_data,
    output logic [7:0]                fpu_opcode,
    output logic [7:0]                fpu_modrm,
    output logic [79:0]               fpu_data_in,
    output logic [31:0]               fpu_int_data_in,
    output logic                      fpu_execute,
    input  logic                      fpu_ready,
    input  logic                      fpu_error,
    input  logic                      err_clear,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    queue_count,
    output logic                      err_sticky,
    output logic                      timeout,
    output logic                      drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic            exec_q, drop_q, err_q, err_d, tmo_q, tmo_d;
    logic [127:0]    mem_q [DEPTH];
    logic [127:0]    head;
    logic            is_esc, accept, push, pop, done, wd_fire;

    assign is_esc    = (esc_opcode[7:3] == 5'b11011);
    assign esc_ready = (count_q != FULL);
    assign accept    = esc_valid && esc_ready;
    assign push      = accept && is_esc;
    assign pop       = done || wd_fire;

    // The head slot cannot be overwritten while it is in flight: a push only
    // targets wr_ptr, which equals rd_ptr solely when the queue is full.
    assign head            = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign fpu_opcode      = head[127:120];
    assign fpu_modrm       = head[119:112];
    assign fpu_data_in     = head[111:32];
    assign fpu_int_data_in = head[31:0];

    assign fpu_execute = exec_q;
    assign drop        = drop_q;
    assign err_sticky  = err_q;
    assign timeout     = tmo_q;
    assign queue_count = count_q;
    assign busy        = (count_q != '0) || (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        done    = 1'b0;
        wd_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0 && fpu_ready && !err_q && !tmo_q) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_GUARD;
            S_GUARD: begin
                state_d = S_WAIT;
                wd_d    = '0;
            end
            S_WAIT: begin
                wd_d = wd_q + WW'(1);
                if (fpu_ready) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else if (wd_q == WD_LAST) begin
                    wd_fire = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A set on the same cycle as a clear must win.
        err_d = err_q;
        if (done && fpu_error) begin
            err_d = 1'b1;
        end else if (err_clear) begin
            err_d = 1'b0;
        end
        tmo_d = tmo_q;
        if (wd_fire) begin
            tmo_d = 1'b1;
        end else if (err_clear) begin
            tmo_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wd_q     <= '0;
            exec_q   <= 1'b0;
            drop_q   <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wd_q    <= wd_d;
            exec_q  <= (state_d == S_ISSUE);
            drop_q  <= accept && !is_esc;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {esc_opcode, esc_modrm, esc_data, esc_int_data};
        end
    end

endmodule

// File: tb/tb_fpu_esc_dispatcher.sv
// Directed bench for fpu_esc_dispatcher: scoreboard of issued instructions plus
// direct checks of queue, error, watchdog and drop behaviour (second instance uses TIMEOUT=8).
module tb_fpu_esc_dispatcher;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        esc_valid = 1'b0;
    logic [7:0]  esc_opcode = '0;
    logic [7:0]  esc_modrm = '0;
    logic [79:0] esc_data = '0;
    logic [31:0] esc_int_data = '0;
    logic        fpu_ready = 1'b0;
    logic        fpu_error = 1'b0;
    logic        err_clear = 1'b0;
    logic        esc_ready, fpu_execute, busy, err_sticky, timeout, drop;
    logic [7:0]  fpu_opcode, fpu_modrm;
    logic [79:0] fpu_data_in;
    logic [31:0] fpu_int_data_in;
    logic [2:0]  queue_count;

    logic        b_valid = 1'b0;
    logic [7:0]  b_opcode = '0;
    logic [7:0]  b_modrm = '0;
    logic [79:0] b_data = '0;
    logic [31:0] b_int_data = '0;
    logic        b_ready = 1'b0;
    logic        b_error = 1'b0;
    logic        b_err_clear = 1'b0;
    logic        b_esc_ready, b_execute, b_busy, b_err_sticky, b_timeout, b_drop;
    logic [7:0]  b_fpu_opcode, b_fpu_modrm;
    logic [79:0] b_fpu_data;
    logic [31:0] b_fpu_int;
    logic [2:0]  b_count;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  modrm;
        logic [79:0] data;
        logic [31:0] idata;
    } entry_t;

    entry_t sb[$];
    int     issue_cyc[$];
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    entry_t mon_e;

    fpu_esc_dispatcher dut (
        .clk(clk), .reset_n(reset_n),
        .esc_valid(esc_valid), .esc_ready(esc_ready), .esc_opcode(esc_opcode),
        .esc_modrm(esc_modrm), .esc_data(esc_data), .esc_int_data(esc_int_data),
        .fpu_opcode(fpu_opcode), .fpu_modrm(fpu_modrm), .fpu_data_in(fpu_data_in),
        .fpu_int_data_in(fpu_int_data_in), .fpu_execute(fpu_execute),
        .fpu_ready(fpu_ready), .fpu_error(fpu_error), .err_clear(err_clear),
        .busy(busy), .queue_count(queue_count), .err_sticky(err_sticky),
        .timeout(timeout), .drop(drop)
    );

    fpu_esc_dispatcher #(.DEPTH(4), .TIMEOUT(8)) dut8 (
        .clk(clk), .reset_n(reset_n),
        .esc_valid(b_valid), .esc_ready(b_esc_ready), .esc_opcode(b_opcode),
        .esc_modrm(b_modrm), .esc_data(b_data), .esc_int_data(b_int_data),
        .fpu_opcode(b_fpu_opcode), .fpu_modrm(b_fpu_modrm), .fpu_data_in(b_fpu_data),
        .fpu_int_data_in(b_fpu_int), .fpu_execute(b_execute),
        .fpu_ready(b_ready), .fpu_error(b_error), .err_clear(b_err_clear),
        .busy(b_busy), .queue_count(b_count), .err_sticky(b_err_sticky),
        .timeout(b_timeout), .drop(b_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic entry_t mk(input logic [7:0] op, input logic [7:0] modrm);
        entry_t e;
        e.op    = op;
        e.modrm = modrm;
        e.data  = {op, modrm, 64'h0123_4567_89AB_CDEF};
        e.idata = {modrm, op, 16'hBEEF};
        return e;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] op, input logic [7:0] modrm, input bit track);
        entry_t e;
        e = mk(op, modrm);
        chk("push_ready", esc_ready, 1);
        esc_valid = 1'b1;
        esc_opcode = op;
        esc_modrm = modrm;
        esc_data = e.data;
        esc_int_data = e.idata;
        if (track) sb.push_back(e);
        $display("push op=%0h modrm=%0h tracked=%0d", op, modrm, track);
        tick();
        esc_valid = 1'b0;
    endtask

    task automatic b_push(input logic [7:0] op, input logic [7:0] modrm);
        entry_t e;
        e = mk(op, modrm);
        chk("b_push_ready", b_esc_ready, 1);
        b_valid = 1'b1;
        b_opcode = op;
        b_modrm = modrm;
        b_data = e.data;
        b_int_data = e.idata;
        $display("push(T8) op=%0h modrm=%0h", op, modrm);
        tick();
        b_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (busy === 1'b0) break;
            tick();
        end
        chk("wait_idle", busy, 0);
    endtask

    // Scoreboard monitor: every execute pulse must carry the oldest expected entry.
    always @(negedge clk) begin
        if (fpu_execute === 1'b1) begin
            issue_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue actual op=%0h required=no issue", fpu_opcode);
            end else begin
                mon_e = sb.pop_front();
                $display("issue op=%0h modrm=%0h cycle=%0d", fpu_opcode, fpu_modrm, cyc);
                chk("issue_opcode", fpu_opcode, mon_e.op);
                chk("issue_modrm", fpu_modrm, mon_e.modrm);
                chk("issue_data", fpu_data_in, mon_e.data);
                chk("issue_int", fpu_int_data_in, mon_e.idata);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL sim_time_limit actual=expired required=finish");
        $fatal(1);
    end

    initial begin
        entry_t h;
        h = mk(8'hDC, 8'hC1);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Fill the queue with the FPU busy, then reset asynchronously.
        for (int i = 0; i < 4; i++) push(8'hD8 + 8'(i), 8'hC0 + 8'(i), 1'b0);
        chk("full_count", queue_count, 4);
        chk("full_ready", esc_ready, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_count", queue_count, 0);
        chk("rst_ready", esc_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_sticky, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_drop", drop, 0);
        chk("rst_exec", fpu_execute, 0);
        chk("rst_opcode", fpu_opcode, 0);
        chk("rst_modrm", fpu_modrm, 0);
        chk("rst_data", fpu_data_in, 0);
        chk("rst_int", fpu_int_data_in, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Issue latency from an empty queue.
        fpu_ready = 1'b1;
        push(8'hD9, 8'hC0, 1'b1);
        chk("lat_k", fpu_execute, 0);
        tick();
        chk("lat_k1", fpu_execute, 1);
        tick();
        chk("lat_k2", fpu_execute, 0);
        wait_idle();

        // Back-to-back pushes: full refusal, ordered issue every 4 cycles.
        issue_cyc.delete();
        push(8'hD8, 8'h01, 1'b1);
        push(8'hD9, 8'h02, 1'b1);
        push(8'hDA, 8'h03, 1'b1);
        push(8'hDB, 8'h04, 1'b1);
        chk("b2b_count4", queue_count, 4);
        esc_valid = 1'b1;
        esc_opcode = 8'hDD;
        esc_modrm = 8'h05;
        chk("b2b_blocked", esc_ready, 0);
        tick();
        esc_valid = 1'b0;
        chk("b2b_count3", queue_count, 3);
        repeat (4) tick();
        chk("b2b_count2", queue_count, 2);
        repeat (4) tick();
        chk("b2b_count1", queue_count, 1);
        repeat (4) tick();
        chk("b2b_count0", queue_count, 0);
        wait_idle();
        chk("b2b_issues", issue_cyc.size(), 4);
        for (int i = 1; i < issue_cyc.size(); i++)
            chk("b2b_spacing", issue_cyc[i] - issue_cyc[i-1], 4);

        // Push coinciding with a pop leaves the count unchanged.
        push(8'hDA, 8'hD0, 1'b1);
        repeat (2) tick();
        push(8'hDB, 8'hD1, 1'b1);
        push(8'hDC, 8'hD2, 1'b1);
        chk("pushpop_count", queue_count, 2);
        wait_idle();

        // Long completion: head outputs stay stable, pop on first ready cycle.
        push(8'hDC, 8'hC1, 1'b1);
        tick();
        fpu_ready = 1'b0;
        chk("hold_exec", fpu_execute, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_opcode", fpu_opcode, h.op);
            chk("hold_modrm", fpu_modrm, h.modrm);
            chk("hold_data", fpu_data_in, h.data);
            chk("hold_int", fpu_int_data_in, h.idata);
            chk("hold_count", queue_count, 1);
        end
        fpu_ready = 1'b1;
        tick();
        chk("hold_pop", queue_count, 0);
        chk("hold_idle", busy, 0);

        // FPU error halts dispatch; set beats a coincident clear.
        push(8'hDE, 8'hF9, 1'b1);
        push(8'hD8, 8'hC2, 1'b1);
        push(8'hD9, 8'hC3, 1'b1);
        tick();
        fpu_error = 1'b1;
        err_clear = 1'b1;
        tick();
        fpu_error = 1'b0;
        err_clear = 1'b0;
        chk("err_set", err_sticky, 1);
        chk("err_count", queue_count, 2);
        push(8'hDA, 8'hC4, 1'b1);
        chk("halt_count", queue_count, 3);
        for (int i = 0; i < 6; i++) begin
            chk("halt_exec", fpu_execute, 0);
            tick();
        end
        chk("halt_busy", busy, 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("err_cleared", err_sticky, 0);
        tick();
        chk("clr_exec", fpu_execute, 1);
        wait_idle();

        // Non-ESC opcode is consumed and dropped.
        esc_valid = 1'b1;
        esc_opcode = 8'h90;
        esc_modrm = 8'h00;
        $display("offer op=90 (non-ESC)");
        tick();
        esc_valid = 1'b0;
        chk("drop_pulse", drop, 1);
        chk("drop_count", queue_count, 0);
        tick();
        chk("drop_clear", drop, 0);
        for (int i = 0; i < 3; i++) begin
            chk("drop_noexec", fpu_execute, 0);
            tick();
        end
        chk("drop_busy", busy, 0);

        // Watchdog (TIMEOUT=8): fires after 8 WAIT_DONE cycles.
        b_ready = 1'b1;
        b_push(8'hDD, 8'hC5);
        tick();
        chk("wd_exec", b_execute, 1);
        b_ready = 1'b0;
        repeat (9) tick();
        chk("wd_pre_timeout", b_timeout, 0);
        chk("wd_pre_count", b_count, 1);
        tick();
        chk("wd_timeout", b_timeout, 1);
        chk("wd_popped", b_count, 0);
        b_ready = 1'b1;
        b_push(8'hD8, 8'hC6);
        for (int i = 0; i < 4; i++) begin
            chk("wd_halt_exec", b_execute, 0);
            tick();
        end
        chk("wd_halt_count", b_count, 1);
        b_err_clear = 1'b1;
        tick();
        b_err_clear = 1'b0;
        chk("wd_cleared", b_timeout, 0);
        tick();
        chk("wd_exec2", b_execute, 1);
        chk("wd_exec2_op", b_fpu_opcode, 8'hD8);
        b_ready = 1'b0;
        repeat (9) tick();
        b_ready = 1'b1;
        tick();
        chk("wd_final_no_timeout", b_timeout, 0);
        chk("wd_final_count", b_count, 0);
        chk("wd_final_err", b_err_sticky, 0);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
